// File: rtl/bus_master_pkg.sv
// Shared types and constants for the 68000-style bus initiator.
package bus_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_RECOVER
  } state_e;

  typedef enum logic [1:0] {
    RES_OK       = 2'b00,
    RES_BERR     = 2'b01,
    RES_TIMEOUT  = 2'b10,
    RES_ADDR_ERR = 2'b11
  } result_e;

  localparam logic [2:0] FC_USER_DATA  = 3'b001;
  localparam logic [2:0] FC_SUPER_DATA = 3'b101;
  localparam logic [2:0] FC_INT_ACK    = 3'b111;

  localparam logic [7:0] AUTOVEC_BASE = 8'd24;

  // Autovector number for an interrupt level taken from A3..A1.
  function automatic logic [15:0] autovec_number(input logic [2:0] level);
    return {8'h00, AUTOVEC_BASE + {5'b00000, level}};
  endfunction

endpackage

// File: rtl/bus_master_if.sv
// Request/response and bus-strobe bundle between the initiator and its responder.
interface bus_master_if;
  logic        REQ_IN;
  logic        REQ_WR_IN;
  logic        REQ_BYTE_IN;
  logic [2:0]  REQ_FC_IN;
  logic [23:0] REQ_ADDR_IN;
  logic [15:0] REQ_WDATA_IN;

  logic        BUSY;
  logic        DONE;
  logic [1:0]  RESULT;
  logic [15:0] RDATA;

  logic [23:0] ADDR_OUT;
  logic [2:0]  MPU_STATUS_CODE_OUT;
  logic        AS_OUT;
  logic        UDS_OUT;
  logic        LDS_OUT;
  logic        WR_OUT;

  logic        DATA_ACK_IN;
  logic        INT_AUTOVEC_ACK_IN;
  logic        BUS_ERROR_ACK_IN;

  modport master (
    input  REQ_IN, REQ_WR_IN, REQ_BYTE_IN, REQ_FC_IN, REQ_ADDR_IN, REQ_WDATA_IN,
    input  DATA_ACK_IN, INT_AUTOVEC_ACK_IN, BUS_ERROR_ACK_IN,
    output BUSY, DONE, RESULT, RDATA,
    output ADDR_OUT, MPU_STATUS_CODE_OUT, AS_OUT, UDS_OUT, LDS_OUT, WR_OUT
  );

  modport slave (
    output REQ_IN, REQ_WR_IN, REQ_BYTE_IN, REQ_FC_IN, REQ_ADDR_IN, REQ_WDATA_IN,
    output DATA_ACK_IN, INT_AUTOVEC_ACK_IN, BUS_ERROR_ACK_IN,
    input  BUSY, DONE, RESULT, RDATA,
    input  ADDR_OUT, MPU_STATUS_CODE_OUT, AS_OUT, UDS_OUT, LDS_OUT, WR_OUT
  );
endinterface

// File: rtl/bus_wait_timer.sv
// Wait-state counter: cleared outside WAIT, counts unacknowledged WAIT cycles.
module bus_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [7:0] count_q, count_d;

  // NOTE: count_d gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 8'(TIMEOUT_CYCLES));

endmodule

// File: rtl/bus_master.sv
// 68000-style single-transfer bus initiator: read, write and interrupt-acknowledge
// cycles terminated by DTACK, AVEC or BERR, with a wait-state timeout.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         CPUCLK_IN,
  input  logic         RESET_IN,
  bus_master_if.master bus,
  inout  wire  [15:0]  DATA
);
  state_e      state_q, state_d;
  result_e     result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] rdata_q, rdata_d;
  logic [23:0] addr_q, addr_d;
  logic [2:0]  fc_q, fc_d;
  logic        wr_q, wr_d;
  logic        byte_q, byte_d;
  logic [15:0] wdata_q, wdata_d;
  logic        as_q, as_d;
  logic        uds_q, uds_d;
  logic        lds_q, lds_d;
  logic        wr_out_q, wr_out_d;
  logic        data_oe_q, data_oe_d;

  logic        req_byte;
  logic        avec_ok;
  logic        ack_seen;
  logic        timer_expired;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;

  // An interrupt acknowledge always uses both strobes, whatever REQ_BYTE_IN says.
  assign req_byte  = bus.REQ_BYTE_IN & (bus.REQ_FC_IN != FC_INT_ACK);
  assign avec_ok   = bus.INT_AUTOVEC_ACK_IN & (fc_q == FC_INT_ACK);
  assign ack_seen  = bus.BUS_ERROR_ACK_IN | bus.DATA_ACK_IN | avec_ok;
  assign bus_wdata = byte_q ? {2{wdata_q[7:0]}} : wdata_q;
  assign bus_rdata = byte_q ? {8'h00, (addr_q[0] ? DATA[7:0] : DATA[15:8])} : DATA;
  assign DATA      = data_oe_q ? bus_wdata : 16'hzzzz;

  bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (CPUCLK_IN),
    .rst    (RESET_IN),
    .clear  (state_q != ST_WAIT),
    .enable ((state_q == ST_WAIT) && !ack_seen),
    .expired(timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    fc_d      = fc_q;
    wr_d      = wr_q;
    byte_d    = byte_q;
    wdata_d   = wdata_q;
    as_d      = as_q;
    uds_d     = uds_q;
    lds_d     = lds_q;
    wr_out_d  = wr_out_q;
    data_oe_d = data_oe_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.REQ_IN) begin
          busy_d  = 1'b1;
          addr_d  = bus.REQ_ADDR_IN;
          fc_d    = bus.REQ_FC_IN;
          wr_d    = bus.REQ_WR_IN;
          byte_d  = req_byte;
          wdata_d = bus.REQ_WDATA_IN;
          if (!req_byte && bus.REQ_ADDR_IN[0]) begin
            state_d  = ST_RECOVER;
            done_d   = 1'b1;
            result_d = RES_ADDR_ERR;
            rdata_d  = '0;
          end else begin
            state_d   = ST_ADDR;
            wr_out_d  = bus.REQ_WR_IN;
            data_oe_d = bus.REQ_WR_IN;
          end
        end
      end
      ST_ADDR: begin
        state_d = ST_WAIT;
        as_d    = 1'b1;
        uds_d   = !byte_q || !addr_q[0];
        lds_d   = !byte_q || addr_q[0];
      end
      ST_WAIT: begin
        if (ack_seen || timer_expired) begin
          state_d   = ST_RECOVER;
          done_d    = 1'b1;
          as_d      = 1'b0;
          uds_d     = 1'b0;
          lds_d     = 1'b0;
          data_oe_d = 1'b0;
          rdata_d   = '0;
          // Acknowledge priority: BERR, then DTACK, then AVEC, timeout last.
          if (bus.BUS_ERROR_ACK_IN) begin
            result_d = RES_BERR;
          end else if (bus.DATA_ACK_IN) begin
            result_d = RES_OK;
            if (!wr_q) rdata_d = bus_rdata;
          end else if (avec_ok) begin
            result_d = RES_OK;
            rdata_d  = autovec_number(addr_q[3:1]);
          end else begin
            result_d = RES_TIMEOUT;
          end
        end
      end
      ST_RECOVER: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        wr_out_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q   <= ST_IDLE;
      result_q  <= RES_OK;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      fc_q      <= '0;
      wr_q      <= 1'b0;
      byte_q    <= 1'b0;
      wdata_q   <= '0;
      as_q      <= 1'b0;
      uds_q     <= 1'b0;
      lds_q     <= 1'b0;
      wr_out_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      fc_q      <= fc_d;
      wr_q      <= wr_d;
      byte_q    <= byte_d;
      wdata_q   <= wdata_d;
      as_q      <= as_d;
      uds_q     <= uds_d;
      lds_q     <= lds_d;
      wr_out_q  <= wr_out_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign bus.BUSY                = busy_q;
  assign bus.DONE                = done_q;
  assign bus.RESULT              = result_q;
  assign bus.RDATA               = rdata_q;
  assign bus.ADDR_OUT            = addr_q;
  assign bus.MPU_STATUS_CODE_OUT = fc_q;
  assign bus.AS_OUT              = as_q;
  assign bus.UDS_OUT             = uds_q;
  assign bus.LDS_OUT             = lds_q;
  assign bus.WR_OUT              = wr_out_q;

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master: directed cases plus randomized transfers
// compared against a transaction-level model of the bus cycle rules.
module tb_bus_master;
  import bus_master_pkg::*;

  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_master_if bus ();

  wire  [15:0] data_bus;
  logic        tb_drv_en  = 1'b0;
  logic [15:0] tb_drv_val = 16'h0000;
  assign data_bus = tb_drv_en ? tb_drv_val : 16'hzzzz;

  bus_master #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CPUCLK_IN(clk),
    .RESET_IN (rst),
    .bus      (bus),
    .DATA     (data_bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_responder();
    bus.DATA_ACK_IN        = 1'b0;
    bus.INT_AUTOVEC_ACK_IN = 1'b0;
    bus.BUS_ERROR_ACK_IN   = 1'b0;
    tb_drv_en              = 1'b0;
  endtask

  task automatic drive_req(input logic wr, input logic byte_req, input logic [2:0] fc,
                           input logic [23:0] addr, input logic [15:0] wdata);
    bus.REQ_IN       = 1'b1;
    bus.REQ_WR_IN    = wr;
    bus.REQ_BYTE_IN  = byte_req;
    bus.REQ_FC_IN    = fc;
    bus.REQ_ADDR_IN  = addr;
    bus.REQ_WDATA_IN = wdata;
  endtask

  // One transfer. berr_at/dtack_at/avec_at name the WAIT cycle (1 = first) in which
  // the responder raises that acknowledge; 0 means never.
  task automatic run_txn(input string name, input logic wr, input logic byte_req,
                         input logic [2:0] fc, input logic [23:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rd_bus,
                         input int berr_at, input int dtack_at, input int avec_at);
    logic        iack, eff_byte, mis, rdata_known, as_seen;
    logic [1:0]  exp_res;
    logic [15:0] exp_rdata, exp_bus;
    int          exp_done, done_c, k;

    iack        = (fc == 3'b111);
    eff_byte    = byte_req && !iack;
    mis         = !eff_byte && addr[0];
    exp_bus     = eff_byte ? {wdata[7:0], wdata[7:0]} : wdata;
    rdata_known = 1'b0;
    exp_res     = 2'b10;
    exp_rdata   = 16'h0000;
    exp_done    = 0;
    if (mis) begin
      exp_res  = 2'b11;
      exp_done = 1;
    end else begin
      for (int w = 1; w <= int'(T) + 1 && exp_done == 0; w++) begin
        if (berr_at == w) begin
          exp_res = 2'b01; exp_rdata = 16'h0000; rdata_known = 1'b1; exp_done = w + 2;
        end else if (dtack_at == w) begin
          exp_res = 2'b00; exp_done = w + 2;
          if (!wr) begin
            rdata_known = 1'b1;
            exp_rdata   = !eff_byte ? rd_bus
                        : (addr[0] ? {8'h00, rd_bus[7:0]} : {8'h00, rd_bus[15:8]});
          end
        end else if (avec_at == w && iack) begin
          exp_res = 2'b00; exp_rdata = 16'(24 + int'(addr[3:1])); rdata_known = 1'b1;
          exp_done = w + 2;
        end else if (w == int'(T) + 1) begin
          exp_res = 2'b10; exp_done = w + 2;
        end
      end
    end

    drive_req(wr, byte_req, fc, addr, wdata);
    @(negedge clk);
    bus.REQ_IN = 1'b0;
    done_c  = 0;
    k       = 0;
    as_seen = 1'b0;
    for (int c = 1; c <= 2 * int'(T) + 10; c++) begin
      if (c == 1) begin
        check({name, "/busy"}, 32'(bus.BUSY), 32'(1));
        if (!mis) begin
          check({name, "/addr"}, 32'(bus.ADDR_OUT), 32'(addr));
          check({name, "/fc"}, 32'(bus.MPU_STATUS_CODE_OUT), 32'(fc));
          check({name, "/wr_addr"}, 32'(bus.WR_OUT), 32'(wr));
          check({name, "/as_addr"}, 32'(bus.AS_OUT), 32'(0));
          if (wr) check({name, "/data_addr"}, 32'(data_bus), 32'(exp_bus));
        end
      end
      if (bus.AS_OUT) begin
        k++;
        as_seen = 1'b1;
        if (k == 1) begin
          check({name, "/uds"}, 32'(bus.UDS_OUT), 32'(!eff_byte || !addr[0]));
          check({name, "/lds"}, 32'(bus.LDS_OUT), 32'(!eff_byte || addr[0]));
          check({name, "/wr_wait"}, 32'(bus.WR_OUT), 32'(wr));
          if (wr) check({name, "/data_wait"}, 32'(data_bus), 32'(exp_bus));
        end
      end
      if (bus.DONE) begin
        done_c = c;
        break;
      end
      bus.BUS_ERROR_ACK_IN   = bus.AS_OUT && (berr_at == k);
      bus.DATA_ACK_IN        = bus.AS_OUT && (dtack_at == k);
      bus.INT_AUTOVEC_ACK_IN = bus.AS_OUT && (avec_at == k);
      tb_drv_en              = bus.AS_OUT && !wr;
      tb_drv_val             = rd_bus;
      @(negedge clk);
    end
    clear_responder();

    if (mis) check({name, "/no_as"}, 32'(as_seen), 32'(0));
    check({name, "/done_cycle"}, 32'(done_c), 32'(exp_done));
    check({name, "/result"}, 32'(bus.RESULT), 32'(exp_res));
    if (rdata_known) check({name, "/rdata"}, 32'(bus.RDATA), 32'(exp_rdata));
    @(negedge clk);
    check({name, "/idle_busy"}, 32'(bus.BUSY), 32'(0));
    check({name, "/idle_done"}, 32'(bus.DONE), 32'(0));
    check({name, "/result_held"}, 32'(bus.RESULT), 32'(exp_res));
  endtask

  task automatic reset_mid_cycle();
    logic done_seen;
    drive_req(1'b0, 1'b0, 3'b101, 24'h000200, 16'h0000);
    @(negedge clk);
    bus.REQ_IN = 1'b0;
    @(negedge clk);
    check("rst/as_before", 32'(bus.AS_OUT), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("rst/as", 32'(bus.AS_OUT), 32'(0));
    check("rst/uds", 32'(bus.UDS_OUT), 32'(0));
    check("rst/lds", 32'(bus.LDS_OUT), 32'(0));
    check("rst/busy", 32'(bus.BUSY), 32'(0));
    check("rst/addr", 32'(bus.ADDR_OUT), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.DONE) done_seen = 1'b1;
    end
    check("rst/no_done", 32'(done_seen), 32'(0));
  endtask

  // A request held high across a whole transfer starts the next one 4 cycles later.
  task automatic back_to_back();
    logic [9:0] as_hist, done_hist;
    as_hist   = '0;
    done_hist = '0;
    drive_req(1'b0, 1'b0, 3'b001, 24'h000010, 16'h0000);
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      as_hist[c]      = bus.AS_OUT;
      done_hist[c]    = bus.DONE;
      bus.DATA_ACK_IN = bus.AS_OUT;
      tb_drv_en       = bus.AS_OUT;
      tb_drv_val      = 16'h1234;
      if (c == 8) bus.REQ_IN = 1'b0;
      @(negedge clk);
    end
    clear_responder();
    check("b2b/as_cycles", 32'(as_hist), 32'(10'b0001000100));
    check("b2b/done_cycles", 32'(done_hist), 32'(10'b0010001000));
    check("b2b/rdata", 32'(bus.RDATA), 32'(16'h1234));
    check("b2b/busy", 32'(bus.BUSY), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] fc;
    int         sel;

    bus.REQ_IN       = 1'b0;
    bus.REQ_WR_IN    = 1'b0;
    bus.REQ_BYTE_IN  = 1'b0;
    bus.REQ_FC_IN    = 3'b000;
    bus.REQ_ADDR_IN  = 24'h000000;
    bus.REQ_WDATA_IN = 16'h0000;
    clear_responder();

    repeat (2) @(negedge clk);
    check("reset/busy", 32'(bus.BUSY), 32'(0));
    check("reset/done", 32'(bus.DONE), 32'(0));
    check("reset/as", 32'(bus.AS_OUT), 32'(0));
    check("reset/uds", 32'(bus.UDS_OUT), 32'(0));
    check("reset/lds", 32'(bus.LDS_OUT), 32'(0));
    check("reset/wr", 32'(bus.WR_OUT), 32'(0));
    check("reset/addr", 32'(bus.ADDR_OUT), 32'(0));
    check("reset/fc", 32'(bus.MPU_STATUS_CODE_OUT), 32'(0));
    check("reset/rdata", 32'(bus.RDATA), 32'(0));
    check("reset/result", 32'(bus.RESULT), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    run_txn("word_rd",    1'b0, 1'b0, FC_SUPER_DATA, 24'h000100, 16'h0000, 16'hBEEF, 0, 2, 0);
    run_txn("byte_wr",    1'b1, 1'b1, FC_USER_DATA,  24'h100005, 16'h005A, 16'h0000, 0, 1, 0);
    run_txn("byte_rd",    1'b0, 1'b1, FC_USER_DATA,  24'h100002, 16'h0000, 16'h12FF, 0, 1, 0);
    run_txn("berr_dtack", 1'b0, 1'b0, FC_USER_DATA,  24'h200000, 16'h0000, 16'hAAAA, 1, 1, 0);
    run_txn("timeout",    1'b0, 1'b0, FC_USER_DATA,  24'h200000, 16'h0000, 16'h0000, 0, 0, 0);
    run_txn("iack_avec",  1'b0, 1'b0, FC_INT_ACK,    24'h000006, 16'h0000, 16'h0000, 0, 0, 1);
    run_txn("avec_ignored", 1'b0, 1'b0, FC_USER_DATA, 24'h000040, 16'h0000, 16'h0000, 0, 0, 1);
    run_txn("misaligned", 1'b0, 1'b0, FC_USER_DATA,  24'h000101, 16'h0000, 16'h0000, 0, 1, 0);
    run_txn("word_wr",    1'b1, 1'b0, FC_SUPER_DATA, 24'h00FFFE, 16'hC3A5, 16'h0000, 0, 3, 0);

    reset_mid_cycle();
    run_txn("after_rst",  1'b0, 1'b0, FC_SUPER_DATA, 24'h000300, 16'h0000, 16'h5555, 0, 1, 0);
    back_to_back();

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 3));
      fc  = (sel == 0) ? FC_USER_DATA : (sel == 1) ? FC_SUPER_DATA :
            (sel == 2) ? FC_INT_ACK : 3'($urandom);
      run_txn("rand",
              (fc == FC_INT_ACK) ? 1'b0 : 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), fc, 24'($urandom), 16'($urandom), 16'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T + 2)) : 0,
              ($urandom_range(0, 4) != 0) ? int'($urandom_range(1, T + 2)) : 0,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, T + 2)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
